sha256_msg_padder: RTL and testbench

Byte-stream message padder and block feeder for the 8-bit SHA-256 core. It accepts raw message bytes from a host-side source over a valid/ready handshake and appends the FIPS 180-4 padding: 0x80, then zero fill, then the 64-bit big-endian message bit length. It emits a contiguous stream of 64-byte blocks toward the core's byte input, with block-boundary markers. It sits between the host byte source and the SHA-256 core's 8-bit load port, and is the transmitting end of that port.

---
 rtl/sha256_msg_padder_if.sv | 27 ++
 rtl/sha256_msg_padder.sv | 147 ++++++++++++++
 tb/tb_sha256_msg_padder.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/sha256_msg_padder_if.sv
// Byte-stream bundle between the host source, the message padder and the
// SHA-256 core load port, plus the padder's status flags.
interface sha256_msg_padder_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_empty;
  logic       s_ready;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       m_first;
  logic       m_blk_end;
  logic       m_msg_end;
  logic       busy;
  logic       err_ovf;

  modport master (
    output s_data, s_valid, s_last, s_empty, m_ready,
    input  s_ready, m_data, m_valid, m_first, m_blk_end, m_msg_end, busy, err_ovf
  );

  modport slave (
    input  s_data, s_valid, s_last, s_empty, m_ready,
    output s_ready, m_data, m_valid, m_first, m_blk_end, m_msg_end, busy, err_ovf
  );
endinterface

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: passes message bytes through, then appends 0x80,
// zero fill and the 64-bit bit length, framed as 64-byte blocks.
module sha256_msg_padder #(
  parameter int unsigned LEN_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  sha256_msg_padder_if.slave  bus
);
  localparam int unsigned POS_W = 6;
  localparam logic [POS_W-1:0] POS_LAST_PAD = POS_W'(55);
  localparam logic [POS_W-1:0] POS_BLK_END  = POS_W'(63);

  typedef enum logic [2:0] {IDLE, DATA, PAD80, ZERO, LEN} state_e;

  state_e           state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [7:0]       m_data_q, m_data_d;
  logic             m_valid_q, m_valid_d;
  logic             m_first_q, m_first_d;
  logic             m_blk_end_q, m_blk_end_d;
  logic             m_msg_end_q, m_msg_end_d;
  logic             busy_q, busy_d;
  logic             err_ovf_q, err_ovf_d;
  logic             out_en_q;

  logic             can_load, m_acc, s_acc, s_byte, load;
  logic [7:0]       load_byte, len_byte;
  logic [63:0]      len_bits;

  assign can_load = !m_valid_q || bus.m_ready;
  assign m_acc    = m_valid_q && bus.m_ready;
  assign bus.s_ready = out_en_q && ((state_q == IDLE) || (state_q == DATA)) && can_load;
  assign s_acc    = bus.s_valid && bus.s_ready;
  assign s_byte   = s_acc && !(bus.s_last && bus.s_empty);

  // Length bytes occupy positions 56..63; low pos bits select the byte, MSB first.
  assign len_bits = 64'({cnt_q, 3'b000});
  assign len_byte = 8'(len_bits >> {~pos_q[2:0], 3'b000});

  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    cnt_d     = cnt_q;
    err_ovf_d = err_ovf_q;
    busy_d    = busy_q;
    load      = 1'b0;
    load_byte = 8'h00;

    case (state_q)
      IDLE, DATA: begin
        if (s_acc) begin
          load = 1'b1;
          if (s_byte) begin
            load_byte = bus.s_data;
            state_d   = bus.s_last ? PAD80 : DATA;
            if (&cnt_q) err_ovf_d = 1'b1;
            else        cnt_d     = cnt_q + LEN_W'(1);
          end else begin
            // Empty final beat: the 0x80 goes straight into the output stage.
            load_byte = 8'h80;
            state_d   = (pos_q == POS_LAST_PAD) ? LEN : ZERO;
          end
        end
      end
      PAD80: begin
        if (can_load) begin
          load      = 1'b1;
          load_byte = 8'h80;
          state_d   = (pos_q == POS_LAST_PAD) ? LEN : ZERO;
        end
      end
      ZERO: begin
        if (can_load) begin
          load = 1'b1;
          if (pos_q == POS_LAST_PAD) state_d = LEN;
        end
      end
      LEN: begin
        if (can_load) begin
          load      = 1'b1;
          load_byte = len_byte;
          if (pos_q == POS_BLK_END) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Single output stage: hold while stalled, reload on any generated beat.
    m_valid_d   = m_valid_q && !bus.m_ready;
    m_data_d    = m_data_q;
    m_first_d   = m_first_q;
    m_blk_end_d = m_blk_end_q;
    m_msg_end_d = m_msg_end_q;
    if (load) begin
      m_valid_d   = 1'b1;
      m_data_d    = load_byte;
      m_first_d   = (pos_q == '0);
      m_blk_end_d = (pos_q == POS_BLK_END);
      m_msg_end_d = (state_q == LEN) && (pos_q == POS_BLK_END);
      pos_d       = pos_q + POS_W'(1);
    end

    if (m_acc && m_msg_end_q) busy_d = 1'b0;
    if (s_acc)                busy_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pos_q       <= '0;
      cnt_q       <= '0;
      m_data_q    <= 8'h00;
      m_valid_q   <= 1'b0;
      m_first_q   <= 1'b0;
      m_blk_end_q <= 1'b0;
      m_msg_end_q <= 1'b0;
      busy_q      <= 1'b0;
      err_ovf_q   <= 1'b0;
      out_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      cnt_q       <= cnt_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      m_first_q   <= m_first_d;
      m_blk_end_q <= m_blk_end_d;
      m_msg_end_q <= m_msg_end_d;
      busy_q      <= busy_d;
      err_ovf_q   <= err_ovf_d;
      out_en_q    <= 1'b1;
    end
  end

  assign bus.m_data    = m_data_q;
  assign bus.m_valid   = m_valid_q;
  assign bus.m_first   = m_first_q;
  assign bus.m_blk_end = m_blk_end_q;
  assign bus.m_msg_end = m_msg_end_q;
  assign bus.busy      = busy_q;
  assign bus.err_ovf   = err_ovf_q;
endmodule

// File: tb/tb_sha256_msg_padder.sv
// Self-checking bench for sha256_msg_padder: table-driven messages, random
// messages against a padding reference model, and an asynchronous reset case.
module tb_sha256_msg_padder;
  typedef logic [7:0] q8_t[$];

  typedef struct {
    int          len;
    bit          sl;
    int          rmode;
    bit          abc;
    int          beats;
    logic [15:0] tail;
    logic        ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] s_data = 8'h00;
  logic s_valid = 1'b0, s_last = 1'b0, s_empty = 1'b0, m_ready = 1'b0;
  bit   sel = 1'b0;

  int vectors = 0;
  int errors  = 0;

  sha256_msg_padder_if bus();
  sha256_msg_padder_if bus4();

  sha256_msg_padder #(.LEN_W(16)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  sha256_msg_padder #(.LEN_W(4))  dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  assign bus.s_data   = s_data;
  assign bus.s_valid  = s_valid && !sel;
  assign bus.s_last   = s_last;
  assign bus.s_empty  = s_empty;
  assign bus.m_ready  = m_ready;
  assign bus4.s_data  = s_data;
  assign bus4.s_valid = s_valid && sel;
  assign bus4.s_last  = s_last;
  assign bus4.s_empty = s_empty;
  assign bus4.m_ready = m_ready;

  logic [7:0] o_data;
  logic o_valid, o_first, o_blk_end, o_msg_end, o_sready, o_busy, o_err;
  always_comb begin
    if (sel) begin
      o_data = bus4.m_data;   o_valid = bus4.m_valid;   o_first = bus4.m_first;
      o_blk_end = bus4.m_blk_end; o_msg_end = bus4.m_msg_end;
      o_sready = bus4.s_ready; o_busy = bus4.busy;       o_err = bus4.err_ovf;
    end else begin
      o_data = bus.m_data;    o_valid = bus.m_valid;    o_first = bus.m_first;
      o_blk_end = bus.m_blk_end; o_msg_end = bus.m_msg_end;
      o_sready = bus.s_ready;  o_busy = bus.busy;        o_err = bus.err_ovf;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference padding: message, 0x80, zeros to 56 mod 64, 64-bit bit length.
  function automatic q8_t build_exp(input q8_t msg, input int w);
    q8_t e;
    longint unsigned maxl, eff, bits;
    e = msg;
    maxl = (64'd1 << w) - 64'd1;
    eff  = (longint'(msg.size()) > maxl) ? maxl : longint'(msg.size());
    bits = eff * 64'd8;
    e.push_back(8'h80);
    while ((e.size() % 64) != 56) e.push_back(8'h00);
    for (int k = 7; k >= 0; k--) e.push_back(8'(bits >> (8 * k)));
    return e;
  endfunction

  task automatic run_msg(input int len, input bit sl, input int rmode, input bit abc,
                         output int nbeats, output logic [15:0] last16, output logic ovf);
    q8_t msg, exp;
    int si, oi, nb, acc_cyc, first_cyc, last_cyc;
    bit held;
    logic [11:0] hv;
    sel = sl;
    msg = {};
    for (int i = 0; i < len; i++) msg.push_back(abc ? 8'(8'h61 + i) : 8'($urandom));
    exp = build_exp(msg, sl ? 4 : 16);
    nb = (len == 0) ? 1 : len;
    si = 0; oi = 0; held = 1'b0; hv = '0;
    acc_cyc = -1; first_cyc = -1; last_cyc = -1;
    last16 = '0;
    for (int cyc = 0; cyc < 5000 && oi < exp.size(); cyc++) begin
      @(negedge clk);
      case (rmode)
        0:       m_ready = 1'b1;
        1:       m_ready = (cyc % 2) == 0;
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      if (si < nb) begin
        s_valid = (rmode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
        s_last  = (si == nb - 1);
        s_empty = (len == 0);
        s_data  = (len == 0) ? 8'h00 : msg[si];
      end else begin
        s_valid = 1'b0; s_last = 1'b0; s_empty = 1'b0; s_data = 8'h00;
      end
      #1;
      if (s_valid && o_sready) begin
        if (acc_cyc < 0) acc_cyc = cyc;
        si++;
      end
      if (held)
        check("stall_hold", {52'd0, o_valid, o_data, o_first, o_blk_end, o_msg_end},
              {52'd0, 1'b1, hv[10:0]});
      if (o_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (m_ready) begin
          check($sformatf("beat%0d", oi), {52'd0, o_data, o_first, o_blk_end, o_msg_end, o_busy},
                {52'd0, exp[oi], (oi % 64) == 0, (oi % 64) == 63, oi == exp.size() - 1, 1'b1});
          last16 = {last16[7:0], o_data};
          last_cyc = cyc;
          oi++;
          held = 1'b0;
        end else begin
          held = 1'b1;
          hv = {1'b1, o_data, o_first, o_blk_end, o_msg_end};
        end
      end else begin
        held = 1'b0;
      end
    end
    check("complete", 64'(oi), 64'(exp.size()));
    check("first_latency", 64'(first_cyc - acc_cyc), 64'd1);
    if (rmode == 0) check("gapless", 64'(last_cyc - first_cyc + 1), 64'(exp.size()));
    s_valid = 1'b0; s_last = 1'b0; s_empty = 1'b0;
    @(negedge clk);
    #1;
    check("idle_after", {62'd0, o_busy, o_valid}, 64'd0);
    nbeats = oi;
    ovf = o_err;
  endtask

  initial begin
    vec_t tbl[8];
    int nb;
    logic [15:0] tail;
    logic ovf;

    tbl[0] = '{3,   1'b0, 0, 1'b1, 64,  16'h0018, 1'b0};
    tbl[1] = '{0,   1'b0, 0, 1'b0, 64,  16'h0000, 1'b0};
    tbl[2] = '{55,  1'b0, 0, 1'b0, 64,  16'h01B8, 1'b0};
    tbl[3] = '{56,  1'b0, 0, 1'b0, 128, 16'h01C0, 1'b0};
    tbl[4] = '{64,  1'b0, 1, 1'b0, 128, 16'h0200, 1'b0};
    tbl[5] = '{120, 1'b0, 2, 1'b0, 192, 16'h03C0, 1'b0};
    tbl[6] = '{15,  1'b1, 0, 1'b0, 64,  16'h0078, 1'b0};
    tbl[7] = '{16,  1'b1, 1, 1'b0, 64,  16'h0078, 1'b1};

    #1 rst_n = 1'b0;
    #2;
    check("reset_vals", {bus.m_valid, bus.m_data, bus.m_first, bus.m_blk_end, bus.m_msg_end,
                         bus.s_ready, bus.busy, bus.err_ovf, bus4.s_ready, bus4.err_ovf}, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1 check("ready_pre", 64'(bus.s_ready), 64'd0);
    @(negedge clk);
    #1 check("ready_post", 64'(bus.s_ready), 64'd1);

    for (int t = 0; t < 8; t++) begin
      run_msg(tbl[t].len, tbl[t].sl, tbl[t].rmode, tbl[t].abc, nb, tail, ovf);
      check($sformatf("t%0d_beats", t), 64'(nb), 64'(tbl[t].beats));
      check($sformatf("t%0d_len", t), 64'(tail), 64'(tbl[t].tail));
      check($sformatf("t%0d_ovf", t), 64'(ovf), 64'(tbl[t].ovf));
    end

    for (int r = 0; r < 12; r++) begin
      int len;
      len = $urandom_range(0, 140);
      run_msg(len, 1'b0, $urandom_range(0, 2), 1'b0, nb, tail, ovf);
      check($sformatf("r%0d_beats", r), 64'(nb), 64'(64 * ((len + 9 + 63) / 64)));
      check($sformatf("r%0d_ovf", r), 64'(ovf), 64'd0);
    end

    // Reset in the middle of a message, then a fresh message from block position 0.
    sel = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      m_ready = 1'b1; s_valid = 1'b1; s_last = 1'b0; s_empty = 1'b0; s_data = 8'(i + 1);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_vals", {bus.m_valid, bus.m_data, bus.m_first, bus.m_blk_end, bus.m_msg_end,
                          bus.s_ready, bus.busy, bus.err_ovf, bus4.err_ovf}, 64'd0);
    s_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("midrst_ready_pre", 64'(bus.s_ready), 64'd0);
    @(negedge clk);
    #1 check("midrst_ready_post", 64'(bus.s_ready), 64'd1);
    run_msg(3, 1'b0, 0, 1'b1, nb, tail, ovf);
    check("post_rst_beats", 64'(nb), 64'd64);
    check("post_rst_len", 64'(tail), 64'h0018);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
